ahb_rr_arbiter: RTL

Round-robin AHB bus arbiter for the shared multi-master AHB interconnect. It grants the common address/control bus to one of MAS_NUMBER masters and drives the address-phase owner index that steers the master-side multiplexor. It tracks the data-phase owner and fixed-length bursts, and holds locked sequences. With the split option compiled in, it masks masters parked by a SPLIT response.

---
 rtl/ahb_rr_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter: grant, address/data owner, burst and lock tracking.
// Optional split masking is compiled in with `define AHB_ARB_SPLIT_EN.
module ahb_rr_arbiter #(
  parameter int MAS_NUMBER     = 16,
  parameter int DEFAULT_MASTER = 0,
  parameter int MID_WIDTH      = $clog2(MAS_NUMBER)
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [MAS_NUMBER-1:0] hbusreq,
  input  logic [MAS_NUMBER-1:0] hlock,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hburst,
  input  logic                  hready,
  input  logic [1:0]            hresp,
  input  logic [MAS_NUMBER-1:0] hsplit,
  output logic [MAS_NUMBER-1:0] hgrant,
  output logic [MID_WIDTH-1:0]  hmaster,
  output logic [MID_WIDTH-1:0]  hmaster_data,
  output logic                  hmastlock
);

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;
  localparam logic [1:0] R_OKAY   = 2'd0;
  localparam logic [1:0] R_SPLIT  = 2'd3;

  localparam logic [MID_WIDTH-1:0] DEF_IDX =
    MID_WIDTH'(DEFAULT_MASTER);
  localparam logic [MAS_NUMBER-1:0] ONE = MAS_NUMBER'(1);

  logic [MID_WIDTH-1:0]  gnt_idx;
  logic [MID_WIDTH-1:0]  rr_ptr;
  logic [MID_WIDTH-1:0]  winner;
  logic [MAS_NUMBER-1:0] split_mask;
  logic [MAS_NUMBER-1:0] cand;
  logic [4:0]            cnt;
  logic [4:0]            cnt_nxt;
  logic [4:0]            burst_len;
  logic                  lock_hold;
  logic                  rearb_ok;

  assign cand      = hbusreq & ~split_mask;
  assign lock_hold = hlock[gnt_idx] & hbusreq[gnt_idx];
  assign rearb_ok  = !lock_hold &&
                     ((cnt == 5'd0) ||
                      (cnt == 5'd1 && hready && htrans == T_SEQ));

  // Round-robin search starting just after the last winner.
  always_comb begin
    int k;
    logic [MID_WIDTH-1:0] kk;
    logic found;
    winner = DEF_IDX;
    found  = 1'b0;
    k      = 0;
    kk     = '0;
    for (int i = 1; i <= MAS_NUMBER; i++) begin
      k  = (int'(rr_ptr) + i) % MAS_NUMBER;
      kk = MID_WIDTH'(k);
      if (!found && cand[kk]) begin
        winner = kk;
        found  = 1'b1;
      end
    end
  end

  // Remaining beats minus one for a fixed-length burst.
  always_comb begin
    burst_len = 5'd0;
    unique case (hburst)
      3'd2, 3'd3: burst_len = 5'd3;
      3'd4, 3'd5: burst_len = 5'd7;
      3'd6, 3'd7: burst_len = 5'd15;
      default:    burst_len = 5'd0;
    endcase
  end

  // Beat counter; an error-class response frees the bus early.
  always_comb begin
    cnt_nxt = cnt;
    if (hready) begin
      unique case (htrans)
        T_NONSEQ: cnt_nxt = burst_len;
        T_SEQ:    if (cnt != 5'd0) cnt_nxt = cnt - 5'd1;
        T_IDLE:   cnt_nxt = 5'd0;
        default:  cnt_nxt = cnt;
      endcase
    end else if (hresp != R_OKAY) begin
      cnt_nxt = 5'd0;
    end
  end

  // Grant, ownership and burst tracking registers.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      hgrant       <= ONE << DEF_IDX;
      gnt_idx      <= DEF_IDX;
      rr_ptr       <= DEF_IDX;
      hmaster      <= DEF_IDX;
      hmaster_data <= DEF_IDX;
      hmastlock    <= 1'b0;
      cnt          <= 5'd0;
    end else begin
      if (rearb_ok) begin
        hgrant  <= ONE << winner;
        gnt_idx <= winner;
        rr_ptr  <= winner;
      end
      if (hready) begin
        hmaster      <= gnt_idx;
        hmastlock    <= hlock[gnt_idx];
        hmaster_data <= hmaster;
      end
      cnt <= cnt_nxt;
    end
  end

`ifdef AHB_ARB_SPLIT_EN
  logic [MAS_NUMBER-1:0] split_set;

  // Park the data-phase owner on its first SPLIT cycle.
  always_comb begin
    split_set = '0;
    if (hresp == R_SPLIT && !hready)
      split_set[hmaster_data] = 1'b1;
  end

  // Release from hsplit takes precedence over a new park.
  always_ff @(posedge hclk) begin
    if (hreset)
      split_mask <= '0;
    else
      split_mask <= (split_mask | split_set) & ~hsplit;
  end
`else
  logic unused_split;

  assign split_mask   = '0;
  assign unused_split = ^hsplit;
`endif

endmodule
